// File: rtl/clock_timing_decoder.sv
// Triple-redundant clock-phase decoder: votes three {R,Q,P} phase codes, tracks the legal
// 8-step code cycle and derives bit-time and computer-phase counters with error reporting.
module clock_timing_decoder #(
    parameter int unsigned BITS_PER_PHASE = 14,
    parameter int unsigned STALL_MAX      = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] A1CODE,
    input  logic [2:0] A2CODE,
    input  logic [2:0] A3CODE,
    input  logic       CLR_ERR,
    output logic [2:0] VCODE,
    output logic       STEP,
    output logic       BIT_STB,
    output logic [3:0] BIT_TIME,
    output logic [1:0] PHASE,
    output logic       PHASE_STB,
    output logic       LOCKED,
    output logic       SEQ_ERR,
    output logic [2:0] CHAN_ERR,
    output logic [7:0] ERR_CNT
);

    typedef enum logic [0:0] {StSearch, StLocked} state_t;

    localparam logic [3:0] BitLast   = 4'(BITS_PER_PHASE - 1);
    localparam logic [7:0] HoldLimit = 8'(STALL_MAX);

    state_t     state_q, state_d;
    logic [2:0] a1_q, a2_q, a3_q;
    logic [2:0] vote, succ, miscmp;
    logic [2:0] vcode_q;
    logic [7:0] hold_q, hold_d;
    logic [3:0] bit_time_q, bit_time_d;
    logic [1:0] phase_q, phase_d;
    logic       step_q, step_d;
    logic       bit_stb_q, bit_stb_d;
    logic       phase_stb_q, phase_stb_d;
    logic       seq_err_q, seq_err_d;
    logic [2:0] chan_err_q, chan_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign vote   = (a1_q & a2_q) | (a1_q & a3_q) | (a2_q & a3_q);
    assign miscmp = {a3_q != vote, a2_q != vote, a1_q != vote};

    // Only legal successor of the currently displayed code.
    always_comb begin
        unique case (vcode_q)
            3'b000: succ = 3'b001;
            3'b001: succ = 3'b011;
            3'b011: succ = 3'b010;
            3'b010: succ = 3'b110;
            3'b110: succ = 3'b111;
            3'b111: succ = 3'b101;
            3'b101: succ = 3'b100;
            3'b100: succ = 3'b000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = '0;
        bit_time_d  = bit_time_q;
        phase_d     = phase_q;
        step_d      = 1'b0;
        bit_stb_d   = 1'b0;
        phase_stb_d = 1'b0;
        seq_err_d   = 1'b0;

        unique case (state_q)
            StSearch: begin
                if (vcode_q == 3'b100 && vote == 3'b000) begin
                    state_d    = StLocked;
                    bit_time_d = '0;
                    phase_d    = '0;
                end
            end
            StLocked: begin
                if (vote == vcode_q) begin
                    if (hold_q == HoldLimit) begin
                        seq_err_d = 1'b1;
                        state_d   = StSearch;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end else if (vote == succ) begin
                    step_d = 1'b1;
                    if (vote == 3'b000) begin
                        bit_stb_d = 1'b1;
                        if (bit_time_q == BitLast) begin
                            bit_time_d  = '0;
                            phase_d     = phase_q + 2'd1;
                            phase_stb_d = 1'b1;
                        end else begin
                            bit_time_d = bit_time_q + 4'd1;
                        end
                    end
                end else begin
                    seq_err_d = 1'b1;
                    state_d   = StSearch;
                end
            end
            default: state_d = StSearch;
        endcase

        // A clear that coincides with a new event keeps that event.
        chan_err_d = CLR_ERR ? miscmp : (chan_err_q | miscmp);
        if (CLR_ERR) begin
            err_cnt_d = {7'd0, seq_err_d};
        end else if (seq_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StSearch;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            vcode_q     <= '0;
            hold_q      <= '0;
            bit_time_q  <= '0;
            phase_q     <= '0;
            step_q      <= 1'b0;
            bit_stb_q   <= 1'b0;
            phase_stb_q <= 1'b0;
            seq_err_q   <= 1'b0;
            chan_err_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            a1_q        <= A1CODE;
            a2_q        <= A2CODE;
            a3_q        <= A3CODE;
            vcode_q     <= vote;
            hold_q      <= hold_d;
            bit_time_q  <= bit_time_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            bit_stb_q   <= bit_stb_d;
            phase_stb_q <= phase_stb_d;
            seq_err_q   <= seq_err_d;
            chan_err_q  <= chan_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign VCODE     = vcode_q;
    assign STEP      = step_q;
    assign BIT_STB   = bit_stb_q;
    assign BIT_TIME  = bit_time_q;
    assign PHASE     = phase_q;
    assign PHASE_STB = phase_stb_q;
    assign LOCKED    = (state_q == StLocked);
    assign SEQ_ERR   = seq_err_q;
    assign CHAN_ERR  = chan_err_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: doc/clock_timing_decoder.md
CLOCK_TIMING_DECODER -- requirements
Module: clock_timing_decoder

Interface
REQ-001 Parameter BITS_PER_PHASE, default 14: bit times per computer phase, legal range 2..16.
REQ-002 Parameter STALL_MAX, default 15: maximum consecutive cycles the voted code may hold while locked, legal range 1..255.
REQ-003 CLK  input  1  system clock; every register updates on the rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 A1CODE  input  3  channel-1 clock-phase code {R,Q,P}.
REQ-006 A2CODE  input  3  channel-2 clock-phase code {R,Q,P}.
REQ-007 A3CODE  input  3  channel-3 clock-phase code {R,Q,P}.
REQ-008 CLR_ERR  input  1  clears the sticky error flags and the error counter.
REQ-009 VCODE  output  3  registered 2-of-3 voted code.
REQ-010 STEP  output  1  one-cycle pulse when the voted code advances legally while locked.
REQ-011 BIT_STB  output  1  one-cycle pulse on the code wrap 100->000 while locked.
REQ-012 BIT_TIME  output  4  bit-time counter, 0..BITS_PER_PHASE-1.
REQ-013 PHASE  output  2  computer phase counter, 0..3.
REQ-014 PHASE_STB  output  1  one-cycle pulse when BIT_TIME wraps to 0.
REQ-015 LOCKED  output  1  high while the sequence tracker is in the LOCKED state.
REQ-016 SEQ_ERR  output  1  one-cycle pulse on an illegal transition or a stall.
REQ-017 CHAN_ERR  output  3  sticky per-channel miscompare flags; bit n-1 is channel n.
REQ-018 ERR_CNT  output  8  saturating count of SEQ_ERR pulses.

Function
REQ-019 The legal code cycle SHALL be 000->001->011->010->110->111->101->100->000.
REQ-020 The three input codes SHALL be registered once; the voted code SHALL be the bitwise 2-of-3 majority of the registered codes; VCODE SHALL be that vote registered.
REQ-021 Any registered channel code that differs from the vote SHALL set its CHAN_ERR bit one cycle later; the bit SHALL hold until CLR_ERR or RST.
REQ-022 State machine states: SEARCH, LOCKED.
REQ-023 SEARCH->LOCKED: a legal step 100->000 is seen; in that same cycle BIT_TIME and PHASE SHALL be loaded with 0 and no strobes SHALL be issued.
REQ-024 In LOCKED, the voted code may hold or advance exactly one legal step; on an advance, STEP SHALL pulse.
REQ-025 In LOCKED, any other change SHALL produce SEQ_ERR, a transition to SEARCH, and the deassertion of LOCKED.
REQ-026 In LOCKED, a hold for more than STALL_MAX consecutive cycles SHALL produce SEQ_ERR and a transition to SEARCH; the hold counter SHALL clear on every advance.
REQ-027 On an advance 100->000 in LOCKED, BIT_STB SHALL pulse and BIT_TIME SHALL increment.
REQ-028 When BIT_TIME = BITS_PER_PHASE-1 and a 100->000 advance occurs, BIT_TIME SHALL wrap to 0, PHASE_STB SHALL pulse, and PHASE SHALL increment modulo 4 (3->0).
REQ-029 In SEARCH, STEP, BIT_STB and PHASE_STB SHALL stay 0, and BIT_TIME and PHASE SHALL hold their values.
REQ-030 Latency: an input change at edge k SHALL appear on VCODE at edge k+2, with the corresponding STEP/BIT_STB/PHASE_STB/SEQ_ERR pulses asserted in the same cycle.
REQ-031 ERR_CNT SHALL increment on each SEQ_ERR and saturate at 255.
REQ-032 If CLR_ERR coincides with SEQ_ERR, ERR_CNT SHALL become 1; if CLR_ERR coincides with a new miscompare, the affected CHAN_ERR bit SHALL be 1.
REQ-033 A single-channel fault SHALL be masked by the vote and SHALL NOT cause SEQ_ERR.

Reset
REQ-034 RST SHALL clear all registers: state SEARCH, VCODE 000, BIT_TIME 0, PHASE 0, all strobes 0, LOCKED 0, CHAN_ERR 000, ERR_CNT 0, hold counter 0.
REQ-035 RST asserted mid-sequence SHALL take effect on the next edge and override every other input, including CLR_ERR.
REQ-036 After reset, the input registers SHALL hold 000, so a first observed code of 000 is not a step.

Verification
REQ-037 All channels step the legal cycle from 000, one step per 2 cycles -> LOCKED after the first 100->000, BIT_STB every 16 cycles, PHASE_STB when BIT_TIME wraps 13->0, PHASE 0->1.
REQ-038 Locked; A2CODE forced to 111 for 10 cycles -> CHAN_ERR=010, no SEQ_ERR, BIT_TIME continues normally.
REQ-039 Locked at 011; all channels jump to 110 -> SEQ_ERR for 1 cycle, LOCKED=0, ERR_CNT=1, BIT_TIME frozen until relock.
REQ-040 Locked; inputs frozen at 010 -> SEQ_ERR on the 16th held cycle (STALL_MAX=15), state SEARCH.
REQ-041 300 forced illegal jumps -> ERR_CNT=255; CLR_ERR together with a further error -> ERR_CNT=1.
REQ-042 RST pulsed while locked at BIT_TIME=7, PHASE=2 -> every output at its reset value the next cycle; relock restarts BIT_TIME and PHASE at 0.
